multicycle_control: RTL and testbench

Multi-cycle sequencer for the RV32I core. It replaces single-cycle opcode decoding with an FSM that steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB. It issues the same datapath control signals as the combinational control unit, plus PC, IR and memory handshake sequencing. It sits between the instruction register and the datapath muxes, ALU control, register file and the shared instruction/data memory port.

---
 rtl/multicycle_control_if.sv | 49 ++++
 rtl/multicycle_control.sv | 175 +++++++++++++++++
 tb/tb_multicycle_control.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// multicycle_control_if
//   Groups the instruction/memory handshake and datapath control lines of the
//   multi-cycle sequencer. Signal suffixes are from the sequencer's point of view.
//   master : the sequencer (reads opcode/ready, drives all control strobes)
//   slave  : the datapath/memory side (supplies opcode/ready, consumes controls)
//   opcode_i      [6:0] instruction[6:0] from IR
//   mem_ready_i         memory port done for the current FETCH/MEM access
//   pc_write_o          PC update strobe
//   ir_write_o          IR load strobe
//   reg_write_o         register file write enable
//   alu_op_o      [2:0] ALU class
//   alu_src_o           1 = immediate as ALU operand 2
//   alu_data1_o         1 = PC as ALU operand 1
//   mem_write_o         data store request
//   mem_read_o          memory read request (fetch or load)
//   men_to_reg_o        1 = memory data to register file
//   branch_jump_o [1:0] next-PC select
//   illegal_o           sticky unknown-opcode flag
//   instr_done_o        one-cycle retire pulse
interface multicycle_control_if;
  logic [6:0] opcode_i;
  logic       mem_ready_i;
  logic       pc_write_o;
  logic       ir_write_o;
  logic       reg_write_o;
  logic [2:0] alu_op_o;
  logic       alu_src_o;
  logic       alu_data1_o;
  logic       mem_write_o;
  logic       mem_read_o;
  logic       men_to_reg_o;
  logic [1:0] branch_jump_o;
  logic       illegal_o;
  logic       instr_done_o;

  modport master (
    input  opcode_i, mem_ready_i,
    output pc_write_o, ir_write_o, reg_write_o, alu_op_o, alu_src_o,
           alu_data1_o, mem_write_o, mem_read_o, men_to_reg_o,
           branch_jump_o, illegal_o, instr_done_o
  );

  modport slave (
    output opcode_i, mem_ready_i,
    input  pc_write_o, ir_write_o, reg_write_o, alu_op_o, alu_src_o,
           alu_data1_o, mem_write_o, mem_read_o, men_to_reg_o,
           branch_jump_o, illegal_o, instr_done_o
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control
//   Multi-cycle sequencer for the RV32I core. Steps each instruction through
//   FETCH, DECODE, EXECUTE, MEM and WB, issuing datapath controls plus PC, IR
//   and memory handshake strobes. Unknown opcodes park the FSM in TRAP.
//   clk_i : clock, all state changes on the rising edge
//   rst_i : synchronous active-high reset
//   bus   : multicycle_control_if.master (opcode/ready in, controls out)
module multicycle_control (
  input logic                 clk_i,
  input logic                 rst_i,
  multicycle_control_if.master bus
);

  localparam logic [2:0] ST_FETCH   = 3'd0;
  localparam logic [2:0] ST_DECODE  = 3'd1;
  localparam logic [2:0] ST_EXECUTE = 3'd2;
  localparam logic [2:0] ST_MEM     = 3'd3;
  localparam logic [2:0] ST_WB      = 3'd4;
  localparam logic [2:0] ST_TRAP    = 3'd5;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  logic [2:0] state_q, state_d;
  logic [6:0] opcode_q, opcode_d;
  logic       illegal_q, illegal_d;

  logic       opcode_legal;
  logic       is_load, is_store, is_branch;
  logic [2:0] dec_alu_op;
  logic       dec_alu_src, dec_alu_data1;
  logic [1:0] dec_branch_jump;

  logic       pc_write_c, ir_write_c, reg_write_c, mem_write_c, mem_read_c;
  logic       men_to_reg_c, show_dec;

  // Legality is judged on the live IR opcode, since DECODE picks the next state
  // in the same cycle the opcode is latched.
  always_comb begin
    opcode_legal = 1'b0;
    case (bus.opcode_i)
      OP_R, OP_I, OP_L, OP_S, OP_B, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR:
        opcode_legal = 1'b1;
      default: opcode_legal = 1'b0;
    endcase
  end

  // Datapath controls come only from the latched opcode so the IR may change
  // after DECODE without disturbing EXECUTE/MEM/WB.
  always_comb begin
    dec_alu_op      = 3'b000;
    dec_alu_src     = 1'b0;
    dec_alu_data1   = 1'b0;
    dec_branch_jump = 2'b00;
    case (opcode_q)
      OP_R:     dec_alu_op = 3'b010;
      OP_I:     begin dec_alu_op = 3'b011; dec_alu_src = 1'b1; end
      OP_L,
      OP_S:     begin dec_alu_op = 3'b000; dec_alu_src = 1'b1; end
      OP_B:     begin dec_alu_op = 3'b001; dec_branch_jump = 2'b01; end
      OP_LUI:   begin dec_alu_op = 3'b100; dec_alu_src = 1'b1; end
      OP_AUIPC: begin dec_alu_op = 3'b101; dec_alu_src = 1'b1; dec_alu_data1 = 1'b1; end
      OP_JAL:   begin
        dec_alu_op = 3'b110; dec_alu_src = 1'b1; dec_alu_data1 = 1'b1; dec_branch_jump = 2'b10;
      end
      OP_JALR:  begin dec_alu_op = 3'b110; dec_alu_src = 1'b1; dec_branch_jump = 2'b11; end
      default:  dec_alu_op = 3'b000;
    endcase
  end

  assign is_load   = (opcode_q == OP_L);
  assign is_store  = (opcode_q == OP_S);
  assign is_branch = (opcode_q == OP_B);

  // Next-state and strobe generation. Memory requests in FETCH/MEM simply
  // hold until mem_ready_i, so the request level never changes mid-access.
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    illegal_d    = illegal_q;
    pc_write_c   = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    mem_write_c  = 1'b0;
    mem_read_c   = 1'b0;
    men_to_reg_c = 1'b0;
    show_dec     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_read_c = 1'b1;
        if (bus.mem_ready_i) begin
          ir_write_c = 1'b1;
          state_d    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        opcode_d = bus.opcode_i;
        if (opcode_legal) begin
          state_d = ST_EXECUTE;
        end else begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end
      end
      ST_EXECUTE: begin
        show_dec = 1'b1;
        if (is_load || is_store) begin
          state_d = ST_MEM;
        end else if (is_branch) begin
          pc_write_c = 1'b1;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        show_dec    = 1'b1;
        mem_read_c  = is_load;
        mem_write_c = is_store;
        if (bus.mem_ready_i) begin
          if (is_store) begin
            pc_write_c = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        show_dec     = 1'b1;
        reg_write_c  = 1'b1;
        pc_write_c   = 1'b1;
        men_to_reg_c = is_load;
        state_d      = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

  // Everything is forced low while reset is held, including the sticky flag,
  // so no strobe can escape during a mid-operation reset.
  assign bus.pc_write_o    = pc_write_c   & ~rst_i;
  assign bus.instr_done_o  = pc_write_c   & ~rst_i;
  assign bus.ir_write_o    = ir_write_c   & ~rst_i;
  assign bus.reg_write_o   = reg_write_c  & ~rst_i;
  assign bus.mem_write_o   = mem_write_c  & ~rst_i;
  assign bus.mem_read_o    = mem_read_c   & ~rst_i;
  assign bus.men_to_reg_o  = men_to_reg_c & ~rst_i;
  assign bus.illegal_o     = illegal_q    & ~rst_i;
  assign bus.alu_op_o      = (show_dec && !rst_i) ? dec_alu_op      : 3'b000;
  assign bus.alu_src_o     = (show_dec && !rst_i) ? dec_alu_src     : 1'b0;
  assign bus.alu_data1_o   = (show_dec && !rst_i) ? dec_alu_data1   : 1'b0;
  assign bus.branch_jump_o = (show_dec && !rst_i) ? dec_branch_jump : 2'b00;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_FETCH;
      opcode_q  <= 7'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Directed bench for the multi-cycle sequencer. Each cycle's expected output
//   vector is queued as the stimulus is driven and popped when the outputs are
//   sampled on the falling edge.
module tb_multicycle_control;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       alu_data1;
    logic       mem_write;
    logic       mem_read;
    logic       men_to_reg;
    logic [1:0] branch_jump;
    logic       illegal;
    logic       instr_done;
  } ctl_t;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src;
    logic       alu_data1;
    logic [1:0] branch_jump;
  } dec_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] GARBAGE  = 7'b1111111;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  ctl_t  expQ[$];
  string tagQ[$];

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode table for the datapath controls of each legal opcode
  function automatic dec_t decode(input logic [6:0] opc);
    dec_t d;
    d = '0;
    case (opc)
      OP_R:     d = '{3'b010, 1'b0, 1'b0, 2'b00};
      OP_I:     d = '{3'b011, 1'b1, 1'b0, 2'b00};
      OP_L:     d = '{3'b000, 1'b1, 1'b0, 2'b00};
      OP_S:     d = '{3'b000, 1'b1, 1'b0, 2'b00};
      OP_B:     d = '{3'b001, 1'b0, 1'b0, 2'b01};
      OP_LUI:   d = '{3'b100, 1'b1, 1'b0, 2'b00};
      OP_AUIPC: d = '{3'b101, 1'b1, 1'b1, 2'b00};
      OP_JAL:   d = '{3'b110, 1'b1, 1'b1, 2'b10};
      OP_JALR:  d = '{3'b110, 1'b1, 1'b0, 2'b11};
      default:  d = '0;
    endcase
    return d;
  endfunction

  function automatic ctl_t decExp(input dec_t d);
    ctl_t e;
    e             = '0;
    e.alu_op      = d.alu_op;
    e.alu_src     = d.alu_src;
    e.alu_data1   = d.alu_data1;
    e.branch_jump = d.branch_jump;
    return e;
  endfunction

  function automatic ctl_t sample();
    return {bus.pc_write_o, bus.ir_write_o, bus.reg_write_o, bus.alu_op_o,
            bus.alu_src_o, bus.alu_data1_o, bus.mem_write_o, bus.mem_read_o,
            bus.men_to_reg_o, bus.branch_jump_o, bus.illegal_o, bus.instr_done_o};
  endfunction

  // Pop the oldest expectation and compare it with the sampled outputs
  task automatic checkOutput();
    ctl_t  exp;
    ctl_t  obs;
    string tag;
    exp = expQ.pop_front();
    tag = tagQ.pop_front();
    obs = sample();
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, check mid-cycle
  task automatic applyStimulus(input logic r, input logic [6:0] opc, input logic rdy,
                               input ctl_t exp, input string tag);
    rst             = r;
    bus.opcode_i    = opc;
    bus.mem_ready_i = rdy;
    expQ.push_back(exp);
    tagQ.push_back(tag);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  // Walk one legal instruction through every phase; the IR only holds the
  // real opcode during DECODE so the latch is exercised.
  task automatic runInstr(input logic [6:0] opc, input int fetchWaits, input int memWaits,
                          input string name);
    dec_t d;
    ctl_t e;
    logic isL, isS, isB;
    d   = decode(opc);
    isL = (opc == OP_L);
    isS = (opc == OP_S);
    isB = (opc == OP_B);
    for (int i = 0; i < fetchWaits; i++) begin
      e = '0; e.mem_read = 1'b1;
      applyStimulus(1'b0, GARBAGE, 1'b0, e, {name, "/fetch_wait"});
    end
    e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1;
    applyStimulus(1'b0, GARBAGE, 1'b1, e, {name, "/fetch"});
    e = '0;
    applyStimulus(1'b0, opc, 1'b1, e, {name, "/decode"});
    e = decExp(d);
    if (isB) begin
      e.pc_write = 1'b1; e.instr_done = 1'b1;
    end
    applyStimulus(1'b0, GARBAGE, 1'b1, e, {name, "/execute"});
    if (isL || isS) begin
      for (int i = 0; i < memWaits; i++) begin
        e = decExp(d); e.mem_read = isL; e.mem_write = isS;
        applyStimulus(1'b0, GARBAGE, 1'b0, e, {name, "/mem_wait"});
      end
      e = decExp(d); e.mem_read = isL; e.mem_write = isS;
      e.pc_write = isS; e.instr_done = isS;
      applyStimulus(1'b0, GARBAGE, 1'b1, e, {name, "/mem_ready"});
    end
    if (!isB && !isS) begin
      e = decExp(d);
      e.reg_write = 1'b1; e.pc_write = 1'b1; e.instr_done = 1'b1; e.men_to_reg = isL;
      applyStimulus(1'b0, GARBAGE, 1'b0, e, {name, "/wb"});
    end
  endtask

  // Directed sequence covering reset, every opcode class, waits, trap and reset mid-load
  initial begin
    ctl_t e;
    compared   = 0;
    mismatched = 0;
    rst             = 1'b1;
    bus.opcode_i    = 7'd0;
    bus.mem_ready_i = 1'b0;
    #1;

    $display("[TB] reset");
    e = '0;
    applyStimulus(1'b1, OP_R, 1'b1, e, "reset0");
    applyStimulus(1'b1, OP_R, 1'b1, e, "reset1");

    $display("[TB] R-type with ready held high, then all classes");
    runInstr(OP_R, 0, 0, "r");
    runInstr(OP_L, 0, 2, "load_wait");
    runInstr(OP_S, 0, 0, "store");
    runInstr(OP_B, 0, 0, "branch");
    runInstr(OP_JAL, 0, 0, "jal");
    runInstr(OP_JALR, 0, 0, "jalr");
    runInstr(OP_I, 2, 0, "itype_fetch_wait");
    runInstr(OP_LUI, 0, 0, "lui");
    runInstr(OP_AUIPC, 0, 0, "auipc");
    runInstr(OP_S, 1, 3, "store_wait");
    runInstr(OP_L, 0, 0, "load");

    $display("[TB] illegal opcode");
    e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1;
    applyStimulus(1'b0, GARBAGE, 1'b1, e, "trap/fetch");
    e = '0;
    applyStimulus(1'b0, GARBAGE, 1'b1, e, "trap/decode");
    for (int i = 0; i < 10; i++) begin
      e = '0; e.illegal = 1'b1;
      applyStimulus(1'b0, OP_R, logic'(i % 2), e, "trap/hold");
    end
    e = '0;
    applyStimulus(1'b1, OP_R, 1'b1, e, "trap/reset");
    e = '0; e.mem_read = 1'b1;
    applyStimulus(1'b0, GARBAGE, 1'b0, e, "trap/after_reset");
    runInstr(OP_R, 0, 0, "r_after_trap");

    $display("[TB] reset during load MEM wait");
    e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1;
    applyStimulus(1'b0, GARBAGE, 1'b1, e, "rstld/fetch");
    e = '0;
    applyStimulus(1'b0, OP_L, 1'b1, e, "rstld/decode");
    e = decExp(decode(OP_L));
    applyStimulus(1'b0, GARBAGE, 1'b1, e, "rstld/execute");
    e = decExp(decode(OP_L)); e.mem_read = 1'b1;
    applyStimulus(1'b0, GARBAGE, 1'b0, e, "rstld/mem_wait");
    e = '0;
    applyStimulus(1'b1, GARBAGE, 1'b1, e, "rstld/reset0");
    applyStimulus(1'b1, GARBAGE, 1'b1, e, "rstld/reset1");
    e = '0; e.mem_read = 1'b1;
    applyStimulus(1'b0, GARBAGE, 1'b0, e, "rstld/fetch_after");
    applyStimulus(1'b0, GARBAGE, 1'b0, e, "rstld/fetch_hold");
    runInstr(OP_B, 0, 0, "branch_after_reset");
    e = '0; e.mem_read = 1'b1;
    applyStimulus(1'b0, GARBAGE, 1'b0, e, "final/fetch");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
